// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-neuron output path
// (rate meter feeding the sigma-delta PDM stage).
package snn_pkg;

  typedef enum logic {
    RATE_WINDOW = 1'b0,
    RATE_EMA    = 1'b1
  } rate_mode_e;

  localparam int unsigned RATE_WIDTH       = 8;
  localparam int unsigned RATE_WINDOW_LOG2 = 8;
  localparam int unsigned RATE_DECAY_SHIFT = 4;

endpackage

// File: rtl/spike_ema.sv
// Leaky exponential moving average of a 1-bit spike train; value is the
// upper WIDTH bits of a WIDTH+DECAY_SHIFT bit accumulator.
module spike_ema
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH       = RATE_WIDTH,
  parameter int unsigned DECAY_SHIFT = RATE_DECAY_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             spike,
  output logic [WIDTH-1:0] value
);

  localparam int unsigned ACC_W = WIDTH + DECAY_SHIFT;
  // (2^WIDTH-1) * 2^DECAY_SHIFT is a fixed point of the update, so it bounds acc.
  localparam logic [ACC_W-1:0] ACC_MAX   = {{WIDTH{1'b1}}, {DECAY_SHIFT{1'b0}}};
  localparam logic [ACC_W-1:0] SPIKE_INC = {{DECAY_SHIFT{1'b0}}, {WIDTH{1'b1}}};

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    acc_next = acc_q - (acc_q >> DECAY_SHIFT) + (spike ? SPIKE_INC : '0);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_next;
    end
  end

  assign value = acc_q[ACC_W-1 -: WIDTH];

  acc_bound_a: assert property (@(posedge clk) disable iff (reset) acc_q <= ACC_MAX);

endmodule

// File: rtl/spike_rate_meter.sv
// Converts a spike train into a WIDTH-bit firing rate, either as a held
// per-window spike count or as a leaky moving average.
module spike_rate_meter
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH       = RATE_WIDTH,
  parameter int unsigned WINDOW_LOG2 = RATE_WINDOW_LOG2,
  parameter int unsigned DECAY_SHIFT = RATE_DECAY_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             spike,
  output logic [WIDTH-1:0] value,
  output logic             value_valid
);

  // value_valid is a one-cycle strobe with no ready: the consumer samples
  // value whenever value_valid is high; value is stable between strobes.

  rate_mode_e             mode_q;
  logic                   mode_change;
  logic                   win_active;
  logic                   win_last;
  logic [WINDOW_LOG2-1:0] win_cnt_q;
  logic [WIDTH-1:0]       spike_cnt_q;
  logic [WIDTH-1:0]       spike_cnt_sat;
  logic [WIDTH-1:0]       win_value_q;
  logic                   value_valid_q;
  logic [WIDTH-1:0]       ema_value;

  always_ff @(posedge clk) begin
    mode_q <= rate_mode_e'(mode);
  end

  always_comb begin
    mode_change   = (rate_mode_e'(mode) != mode_q);
    win_active    = enable && (mode_q == RATE_WINDOW) && !mode_change;
    win_last      = (win_cnt_q == '1);
    spike_cnt_sat = (spike && (spike_cnt_q != '1)) ? spike_cnt_q + WIDTH'(1) : spike_cnt_q;
  end

  // The final cycle's spike closes into this window's result.
  always_ff @(posedge clk) begin
    if (reset || mode_change) begin
      win_cnt_q     <= '0;
      spike_cnt_q   <= '0;
      win_value_q   <= '0;
      value_valid_q <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      if (win_active) begin
        win_cnt_q <= win_cnt_q + WINDOW_LOG2'(1);
        if (win_last) begin
          win_value_q   <= spike_cnt_sat;
          spike_cnt_q   <= '0;
          value_valid_q <= 1'b1;
        end else begin
          spike_cnt_q <= spike_cnt_sat;
        end
      end else if (enable && (mode_q == RATE_EMA)) begin
        value_valid_q <= 1'b1;
      end
    end
  end

  spike_ema #(
    .WIDTH       (WIDTH),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_ema (
    .clk    (clk),
    .reset  (reset),
    .clear  (mode_change),
    .enable (enable && (mode_q == RATE_EMA)),
    .spike  (spike),
    .value  (ema_value)
  );

  // Both sources are registers; the idle estimator is held at zero.
  assign value       = (mode_q == RATE_EMA) ? ema_value : win_value_q;
  assign value_valid = value_valid_q;

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed and randomized checks of spike_rate_meter against an
// arithmetic reference model of both rate estimators.
module tb_spike_rate_meter;

  localparam int WIDTH       = 8;
  localparam int WINDOW_LOG2 = 8;
  localparam int DECAY_SHIFT = 4;
  localparam int WIN_LEN     = 1 << WINDOW_LOG2;
  localparam int VMAX        = (1 << WIDTH) - 1;
  localparam int ACC_MAX     = VMAX << DECAY_SHIFT;

  // clock / reset
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic mode   = 1'b0;
  logic spike  = 1'b0;
  logic [WIDTH-1:0] value;
  logic             value_valid;

  always #5 clk = ~clk;

  spike_rate_meter #(
    .WIDTH       (WIDTH),
    .WINDOW_LOG2 (WINDOW_LOG2),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .spike       (spike),
    .value       (value),
    .value_valid (value_valid)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_mode_q;
  int         m_wcnt;
  int         m_spikes;
  int         m_acc;
  logic [WIDTH-1:0] exp_value;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_q[$];
  int         pulses;

  task automatic model_step();
    if (reset) begin
      m_mode_q = int'(mode); m_wcnt = 0; m_spikes = 0; m_acc = 0;
      exp_value = '0; exp_valid = 1'b0;
    end else if (int'(mode) != m_mode_q) begin
      m_mode_q = int'(mode); m_wcnt = 0; m_spikes = 0; m_acc = 0;
      exp_value = '0; exp_valid = 1'b0;
    end else if (!enable) begin
      exp_valid = 1'b0;
    end else if (m_mode_q == 0) begin
      m_spikes = m_spikes + int'(spike);
      m_wcnt   = m_wcnt + 1;
      exp_valid = 1'b0;
      if (m_wcnt == WIN_LEN) begin
        exp_value = WIDTH'((m_spikes > VMAX) ? VMAX : m_spikes);
        exp_valid = 1'b1;
        exp_q.push_back(exp_value);
        m_wcnt = 0;
        m_spikes = 0;
      end
    end else begin
      m_acc = m_acc - m_acc / (1 << DECAY_SHIFT) + (spike ? VMAX : 0);
      exp_value = WIDTH'(m_acc / (1 << DECAY_SHIFT));
      exp_valid = 1'b1;
    end
  endtask

  // scoreboard
  task automatic check_outputs();
    logic [WIDTH-1:0] got;
    checks++;
    assert (value === exp_value) else begin
      errors++;
      $error("FAIL value observed=%0d expected=%0d t=%0t", value, exp_value, $time);
    end
    checks++;
    assert (value_valid === exp_valid) else begin
      errors++;
      $error("FAIL value_valid observed=%0b expected=%0b t=%0t", value_valid, exp_valid, $time);
    end
    checks++;
    assert (int'(dut.u_ema.acc_q) <= ACC_MAX) else begin
      errors++;
      $error("FAIL acc_bound observed=%0d expected<=%0d", dut.u_ema.acc_q, ACC_MAX);
    end
    if (value_valid === 1'b1 && m_mode_q == 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL window_pulse observed=pulse expected=no_pulse t=%0t", $time);
      end else begin
        got = exp_q.pop_front();
        assert (value === got) else begin
          errors++;
          $error("FAIL window_result observed=%0d expected=%0d", value, got);
        end
      end
    end
  endtask

  // driver
  task automatic cycle(input logic r, input logic e, input logic s, input logic m);
    reset = r; enable = e; spike = s; mode = m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (value_valid === 1'b1) pulses++;
  endtask

  initial begin
    int first;
    int hit;
    logic [WIDTH-1:0] prev;
    logic e, s, m;

    // reset state
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // window mode, spike every cycle: saturated 255, pulse at enabled cycle 256
    pulses = 0; first = -1;
    for (int i = 1; i <= 2 * WIN_LEN; i++) begin
      cycle(0, 1, 1, 0);
      if (value_valid === 1'b1 && first < 0) first = i;
    end
    checks++;
    assert (first == WIN_LEN && pulses == 2) else begin
      errors++;
      $error("FAIL sat_window first=%0d pulses=%0d expected first=%0d pulses=2", first, pulses, WIN_LEN);
    end

    // window mode, enable toggling, spike every 4th enabled cycle -> 64
    cycle(1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 4 * WIN_LEN; i++) begin
      e = (i % 2 == 0);
      s = e && (((i / 2) % 4) == 3);
      cycle(0, e, s, 0);
      if (value_valid === 1'b1) begin
        checks++;
        assert (value === 8'd64) else begin
          errors++;
          $error("FAIL toggle_window observed=%0d expected=64", value);
        end
      end
    end
    checks++;
    assert (pulses == 2) else begin
      errors++;
      $error("FAIL toggle_pulses observed=%0d expected=2", pulses);
    end

    // reset mid-window discards partial count; next window counts final spike
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 1, (i < 30), 0);
    pulses = 0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < WIN_LEN; i++) cycle(0, 1, ((i % 28) == 27) || (i == WIN_LEN - 1), 0);
    checks++;
    assert (value_valid === 1'b1 && value === 8'd10 && pulses == 1) else begin
      errors++;
      $error("FAIL reset_window observed=%0d/%0b/%0d expected=10/1/1", value, value_valid, pulses);
    end

    // EMA rise: monotonic, reaches 255 within 160 cycles
    cycle(1, 0, 0, 1);
    hit = -1; prev = '0;
    for (int i = 1; i <= 160; i++) begin
      cycle(0, 1, 1, 1);
      checks++;
      assert (value >= prev) else begin
        errors++;
        $error("FAIL ema_monotonic observed=%0d expected>=%0d", value, prev);
      end
      prev = value;
      if (value === 8'(VMAX) && hit < 0) hit = i;
    end
    checks++;
    assert (hit > 0) else begin
      errors++;
      $error("FAIL ema_rise observed=%0d expected=%0d", value, VMAX);
    end

    // EMA decay: below 128 within 12 cycles, then to 0
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 1);
    checks++;
    assert (value < 8'd128) else begin
      errors++;
      $error("FAIL ema_decay observed=%0d expected<128", value);
    end
    for (int i = 0; i < 150; i++) cycle(0, 1, 0, 1);
    checks++;
    assert (value === 8'd0) else begin
      errors++;
      $error("FAIL ema_zero observed=%0d expected=0", value);
    end

    // EMA -> window switch clears value; first window after full length
    for (int i = 0; i < 100 && value < 8'd200; i++) cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    checks++;
    assert (value === 8'd0 && value_valid === 1'b0) else begin
      errors++;
      $error("FAIL mode_switch observed=%0d/%0b expected=0/0", value, value_valid);
    end
    first = -1;
    for (int i = 1; i <= WIN_LEN; i++) begin
      cycle(0, 1, 1'($urandom_range(0, 1)), 0);
      if (value_valid === 1'b1 && first < 0) first = i;
    end
    checks++;
    assert (first == WIN_LEN) else begin
      errors++;
      $error("FAIL switch_window first=%0d expected=%0d", first, WIN_LEN);
    end

    // randomized spike / enable / mode / reset
    m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) m = ~m;
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), m);
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missed_windows observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
